// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period modes, fixed code tables and the popcount helper
// used by every lane encoder.
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL  = 3'd0,
        MODE_VIDEO = 3'd1,
        MODE_VGB   = 3'd2,
        MODE_DIGB  = 3'd3,
        MODE_DATA  = 3'd4
    } mode_t;

    localparam logic [9:0] CTRL_CODE [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] VGB_CODE_A = 10'b1011001100;
    localparam logic [9:0] VGB_CODE_B = 10'b0100110011;
    localparam logic [9:0] DIGB_CODE  = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: picks XOR or XNOR chaining from the byte's
// popcount and reports the ones/zeros balance of the resulting q_m[7:0].
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic [7:0] video,
    output logic [8:0] q_m,
    output logic [3:0] n1,
    output logic [3:0] n0
);

    logic [3:0] ones_in;
    logic       use_xnor;

    assign ones_in  = popcount8(video);
    assign use_xnor = (ones_in > 4'd4) || ((ones_in == 4'd4) && !video[0]);

    always_comb begin
        logic [8:0] qm_v;
        qm_v    = '0;
        qm_v[0] = video[0];
        for (int i = 1; i < 8; i++) begin
            qm_v[i] = use_xnor ? ~(qm_v[i-1] ^ video[i]) : (qm_v[i-1] ^ video[i]);
        end
        qm_v[8] = ~use_xnor;
        q_m     = qm_v;
    end

    assign n1 = popcount8(q_m[7:0]);
    assign n0 = 4'd8 - n1;

endmodule

// File: rtl/tmds_multimode_encoder.sv
// Per-lane TMDS encoder covering control, video, guard-band and TERC4 periods,
// with a 1- or 2-cycle pipeline and a sticky illegal-mode flag.
module tmds_multimode_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int CNT_W   = 8,
    parameter int PIPE    = 2
) (
    input  logic                    clk_pixel,
    input  logic                    reset_n,
    input  logic [2:0]              mode,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic [1:0]              ctl,
    input  logic [7:0]              video,
    input  logic [3:0]              nibble,
    output logic [9:0]              out,
    output logic signed [CNT_W-1:0] disparity,
    output logic                    mode_err
);

    logic [8:0] qm_next;
    logic [3:0] n1_next, n0_next;
    logic [1:0] ckey_next;
    logic [3:0] tidx_next;

    tmds_qm_stage u_qm (
        .video (video),
        .q_m   (qm_next),
        .n1    (n1_next),
        .n0    (n0_next)
    );

    // Lane 0 carries sync in DIGB; everything else TERC4-coded uses the nibble.
    assign ckey_next = (CHANNEL == 0) ? {vsync, hsync} : ctl;
    assign tidx_next = (mode == MODE_DIGB) ? {2'b11, vsync, hsync} : nibble;

    logic [2:0] mode_s2;
    logic [8:0] qm_s2;
    logic [3:0] n1_s2, n0_s2;
    logic [1:0] ckey_s2;
    logic [3:0] tidx_s2;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic [2:0] mode_reg;
            logic [8:0] qm_reg;
            logic [3:0] n1_reg, n0_reg;
            logic [1:0] ckey_reg;
            logic [3:0] tidx_reg;

            always_ff @(posedge clk_pixel or negedge reset_n) begin
                if (!reset_n) begin
                    mode_reg <= '0;
                    qm_reg   <= '0;
                    n1_reg   <= '0;
                    n0_reg   <= '0;
                    ckey_reg <= '0;
                    tidx_reg <= '0;
                end else begin
                    mode_reg <= mode;
                    qm_reg   <= qm_next;
                    n1_reg   <= n1_next;
                    n0_reg   <= n0_next;
                    ckey_reg <= ckey_next;
                    tidx_reg <= tidx_next;
                end
            end

            assign mode_s2 = mode_reg;
            assign qm_s2   = qm_reg;
            assign n1_s2   = n1_reg;
            assign n0_s2   = n0_reg;
            assign ckey_s2 = ckey_reg;
            assign tidx_s2 = tidx_reg;
        end else begin : g_pipe1
            assign mode_s2 = mode;
            assign qm_s2   = qm_next;
            assign n1_s2   = n1_next;
            assign n0_s2   = n0_next;
            assign ckey_s2 = ckey_next;
            assign tidx_s2 = tidx_next;
        end
    endgenerate

    logic [9:0]              out_reg, out_next;
    logic signed [CNT_W-1:0] cnt_reg, cnt_next;
    logic                    err_reg, err_next;

    logic signed [CNT_W-1:0] n1_ext, n0_ext, diff, q8x2, nq8x2;
    logic                    q8, cnt_zero, cnt_neg, cnt_pos;

    assign q8       = qm_s2[8];
    assign n1_ext   = {{(CNT_W-4){1'b0}}, n1_s2};
    assign n0_ext   = {{(CNT_W-4){1'b0}}, n0_s2};
    assign diff     = n1_ext - n0_ext;
    assign q8x2     = {{(CNT_W-2){1'b0}}, q8, 1'b0};
    assign nq8x2    = {{(CNT_W-2){1'b0}}, ~q8, 1'b0};
    assign cnt_zero = (cnt_reg == '0);
    assign cnt_neg  = cnt_reg[CNT_W-1];
    assign cnt_pos  = !cnt_neg && !cnt_zero;

    // Any non-video period resets the running disparity to zero.
    always_comb begin
        out_next = CTRL_CODE[ckey_s2];
        cnt_next = '0;
        err_next = err_reg;
        case (mode_s2)
            MODE_CTRL: ;
            MODE_VIDEO: begin
                if (cnt_zero || (n1_s2 == n0_s2)) begin
                    out_next = {~q8, q8, q8 ? qm_s2[7:0] : ~qm_s2[7:0]};
                    cnt_next = cnt_reg + (q8 ? diff : -diff);
                end else if ((cnt_pos && (n1_s2 > n0_s2)) || (cnt_neg && (n0_s2 > n1_s2))) begin
                    out_next = {1'b1, q8, ~qm_s2[7:0]};
                    cnt_next = cnt_reg + q8x2 - diff;
                end else begin
                    out_next = {1'b0, q8, qm_s2[7:0]};
                    cnt_next = cnt_reg + diff - nq8x2;
                end
            end
            MODE_VGB:  out_next = (CHANNEL == 1) ? VGB_CODE_B : VGB_CODE_A;
            MODE_DIGB: out_next = (CHANNEL == 0) ? TERC4_CODE[tidx_s2] : DIGB_CODE;
            MODE_DATA: out_next = TERC4_CODE[tidx_s2];
            default:   err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= '0;
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    assign out       = out_reg;
    assign disparity = cnt_reg;
    assign mode_err  = err_reg;

endmodule

// File: tb/tb_tmds_multimode_encoder.sv
// Four encoder instances (lanes 0/1/2, CNT_W 5/8, PIPE 1/2) share one stimulus
// stream and are checked against an independent behavioural TMDS model.
module tb_tmds_multimode_encoder;

    typedef struct packed {
        logic [2:0] mode;
        logic       hs;
        logic       vs;
        logic [1:0] ctl;
        logic [7:0] video;
        logic [3:0] nib;
    } in_t;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b1;
    logic [2:0] mode      = '0;
    logic       hsync     = 1'b0;
    logic       vsync     = 1'b0;
    logic [1:0] ctl       = '0;
    logic [7:0] video     = '0;
    logic [3:0] nibble    = '0;

    logic [9:0]        out_w      [0:3];
    logic              mode_err_w [0:3];
    logic signed [7:0] disp0, disp2;
    logic signed [4:0] disp1, disp3;

    int ch_of   [0:3] = '{0, 1, 2, 0};
    int pipe_of [0:3] = '{2, 2, 1, 1};

    logic [9:0] ctrl_tab [0:3] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    logic [9:0] terc4_tab [0:15] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  mcnt [0:3];
    bit  merr [0:3];
    in_t prev_in;
    bit  prev_valid;

    always #5 clk_pixel = ~clk_pixel;

    tmds_multimode_encoder #(.CHANNEL(0), .CNT_W(8), .PIPE(2)) u_d0 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode), .hsync(hsync),
        .vsync(vsync), .ctl(ctl), .video(video), .nibble(nibble),
        .out(out_w[0]), .disparity(disp0), .mode_err(mode_err_w[0]));
    tmds_multimode_encoder #(.CHANNEL(1), .CNT_W(5), .PIPE(2)) u_d1 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode), .hsync(hsync),
        .vsync(vsync), .ctl(ctl), .video(video), .nibble(nibble),
        .out(out_w[1]), .disparity(disp1), .mode_err(mode_err_w[1]));
    tmds_multimode_encoder #(.CHANNEL(2), .CNT_W(8), .PIPE(1)) u_d2 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode), .hsync(hsync),
        .vsync(vsync), .ctl(ctl), .video(video), .nibble(nibble),
        .out(out_w[2]), .disparity(disp2), .mode_err(mode_err_w[2]));
    tmds_multimode_encoder #(.CHANNEL(0), .CNT_W(5), .PIPE(1)) u_d3 (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode), .hsync(hsync),
        .vsync(vsync), .ctl(ctl), .video(video), .nibble(nibble),
        .out(out_w[3]), .disparity(disp3), .mode_err(mode_err_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int get_disp(input int k);
        case (k)
            0:       return int'(disp0);
            1:       return int'(disp1);
            2:       return int'(disp2);
            default: return int'(disp3);
        endcase
    endfunction

    function automatic int ones8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // Behavioural symbol model for instance k; updates that instance's counter and error flag.
    function automatic logic [9:0] ref_sym(input int k, input in_t s);
        logic [9:0] sym;
        logic [7:0] qm;
        int         n1, n0, q8;
        bit         use_xnor;
        mcnt[k] = 0;
        case (s.mode)
            3'd0: sym = ctrl_tab[(ch_of[k] == 0) ? {s.vs, s.hs} : s.ctl];
            3'd1: begin
                use_xnor = (ones8(s.video) > 4) || (ones8(s.video) == 4 && !s.video[0]);
                qm[0] = s.video[0];
                for (int i = 1; i < 8; i++)
                    qm[i] = use_xnor ? ~(qm[i-1] ^ s.video[i]) : (qm[i-1] ^ s.video[i]);
                q8 = use_xnor ? 0 : 1;
                n1 = ones8(qm);
                n0 = 8 - n1;
                mcnt[k] = get_cnt_state(k);
                if (mcnt[k] == 0 || n1 == n0) begin
                    sym = (q8 == 1) ? {2'b01, qm} : {2'b10, ~qm};
                    mcnt[k] += (q8 == 1) ? (n1 - n0) : (n0 - n1);
                end else if ((mcnt[k] > 0 && n1 > n0) || (mcnt[k] < 0 && n0 > n1)) begin
                    sym = {1'b1, q8[0], ~qm};
                    mcnt[k] += 2 * q8 + (n0 - n1);
                end else begin
                    sym = {1'b0, q8[0], qm};
                    mcnt[k] += (n1 - n0) - 2 * (1 - q8);
                end
            end
            3'd2: sym = (ch_of[k] == 1) ? 10'b0100110011 : 10'b1011001100;
            3'd3: sym = (ch_of[k] == 0) ? terc4_tab[{2'b11, s.vs, s.hs}] : 10'b0100110011;
            3'd4: sym = terc4_tab[s.nib];
            default: begin
                sym = ctrl_tab[(ch_of[k] == 0) ? {s.vs, s.hs} : s.ctl];
                merr[k] = 1'b1;
            end
        endcase
        return sym;
    endfunction

    // Counter value before this symbol; saved so non-video periods can clear mcnt first.
    int cnt_state [0:3];
    function automatic int get_cnt_state(input int k);
        return cnt_state[k];
    endfunction

    task automatic step(input logic [2:0] m, input logic hs, input logic vs, input logic [1:0] c,
                        input logic [7:0] v, input logic [3:0] nb, input bit verbose);
        in_t        cur, src;
        bit         ok;
        logic [9:0] exp;
        int         d;
        mode = m; hsync = hs; vsync = vs; ctl = c; video = v; nibble = nb;
        @(posedge clk_pixel);
        #1;
        cur = '{m, hs, vs, c, v, nb};
        for (int k = 0; k < 4; k++) begin
            src = (pipe_of[k] == 1) ? cur : prev_in;
            ok  = (pipe_of[k] == 1) ? 1'b1 : prev_valid;
            if (ok) begin
                exp = ref_sym(k, src);
                cnt_state[k] = mcnt[k];
                d = get_disp(k);
                check($sformatf("out_d%0d", k), 32'(out_w[k]), 32'(exp));
                check($sformatf("disp_d%0d", k), d, mcnt[k]);
                check($sformatf("err_d%0d", k), 32'(mode_err_w[k]), 32'(merr[k]));
                check($sformatf("bound_d%0d", k), 32'((d <= 10) && (d >= -10)), 32'd1);
            end
        end
        prev_in    = cur;
        prev_valid = 1'b1;
        if (verbose)
            $display("[TB] mode=%0d hs=%0b vs=%0b ctl=%0d video=%02h nib=%0d | out %03h %03h %03h %03h disp %0d %0d %0d %0d",
                     m, hs, vs, c, v, nb, out_w[0], out_w[1], out_w[2], out_w[3],
                     get_disp(0), get_disp(1), get_disp(2), get_disp(3));
    endtask

    task automatic reset_and_check(input string tag);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_out_d%0d", tag, k), 32'(out_w[k]), 32'd0);
            check($sformatf("%s_disp_d%0d", tag, k), get_disp(k), 0);
            check($sformatf("%s_err_d%0d", tag, k), 32'(mode_err_w[k]), 32'd0);
            mcnt[k] = 0; cnt_state[k] = 0; merr[k] = 1'b0;
        end
        prev_valid = 1'b0;
        $display("[TB] reset %s applied", tag);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mcnt[k] = 0; cnt_state[k] = 0; merr[k] = 1'b0;
        end
        prev_in = '0;
        prev_valid = 1'b0;

        #2;
        reset_and_check("por");
        @(negedge clk_pixel);
        reset_n = 1'b1;

        // Two zero bytes: 0x100 then 0x3FF on the PIPE=2 lane.
        step(3'd1, 0, 0, 2'd0, 8'h00, 4'd0, 1);
        step(3'd1, 0, 0, 2'd0, 8'h00, 4'd0, 1);
        check("v00_first", 32'(out_w[0]), 32'h100);
        check("v00_first_cnt", get_disp(0), -8);
        step(3'd0, 0, 0, 2'd0, 8'h00, 4'd0, 1);
        check("v00_second", 32'(out_w[0]), 32'h3FF);
        check("v00_second_cnt", get_disp(0), 2);

        for (int k = 0; k < 4; k++) begin
            step(3'd0, k[0], k[1], 2'(3 - k), 8'h00, 4'd0, 1);
            check("ctrl_lane0", 32'(out_w[3]), 32'(ctrl_tab[k]));
            check("ctrl_cnt", get_disp(3), 0);
        end

        for (int n = 0; n < 16; n++) begin
            step(3'd4, 0, 0, 2'd0, 8'h00, 4'(n), 1);
            check("terc4_lane2", 32'(out_w[2]), 32'(terc4_tab[n]));
        end
        step(3'd3, 0, 1, 2'd0, 8'h00, 4'd0, 1);
        check("digb_lane0", 32'(out_w[3]), 32'(10'b0101100011));
        check("digb_lane2", 32'(out_w[2]), 32'(10'b0100110011));

        for (int i = 0; i < 3; i++) step(3'd1, 0, 0, 2'd0, 8'hFF, 4'd0, 1);
        check("cnt_nonzero", 32'(get_disp(3) != 0), 32'd1);
        step(3'd2, 0, 0, 2'd0, 8'h00, 4'd0, 1);
        check("vgb_lane0", 32'(out_w[3]), 32'(10'b1011001100));
        check("vgb_cnt", get_disp(3), 0);
        step(3'd1, 0, 0, 2'd0, 8'h10, 4'd0, 1);
        check("post_gb_sym", 32'(out_w[3]), 32'h1F0);
        check("post_gb_cnt", get_disp(3), 0);

        step(3'd6, 1, 0, 2'd2, 8'h00, 4'd0, 1);
        check("illegal_out", 32'(out_w[3]), 32'(ctrl_tab[1]));
        check("illegal_err", 32'(mode_err_w[3]), 32'd1);
        step(3'd1, 0, 0, 2'd0, 8'h55, 4'd0, 1);
        step(3'd0, 0, 0, 2'd0, 8'h00, 4'd0, 1);
        check("err_sticky", 32'(mode_err_w[0]), 32'd1);

        reset_and_check("mid");
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            step(3'd1, 0, 0, 2'd0, 8'($urandom_range(0, 255)), 4'd0, 0);
            if ((i + 1) % 1000 == 0)
                $display("[TB] random video: %0d bytes, %0d comparisons so far", i + 1, tests_run);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
